// File: rtl/soft_intr_ctrl.sv
// ---------------------------------------------------------------------------
// soft_intr_ctrl
//
// Consumer end of the soft-interrupt pulse interface. Single-cycle event
// pulses from N_SRC sources are latched into a pending register. Enabled
// pending sources are arbitrated by fixed priority (lowest index wins), and
// one interrupt at a time is presented to the CPU.
//
// CPU handshake:
//   intr_req is a registered level that plays the role of "valid", and
//   intr_id qualifies it. While intr_req=1, intr_id is held stable. A
//   one-cycle intr_ack pulse while intr_req=1 plays the role of "ready" and
//   consumes the request: intr_req falls on that edge, and the acknowledged
//   pending bit is cleared. An intr_ack seen while intr_req=0 has no effect.
//   A request can also be withdrawn, without an ack, when software clears
//   its pending bit or masks it.
//
// After each ack the controller stays quiet for GAP_CYCLES cycles before it
// arbitrates again. Higher-priority arrivals never preempt a request that is
// already being presented.
//
// Ports:
//   clk        system clock
//   rstn       asynchronous active-low reset
//   src_pulse  per-source event; each high cycle is one event
//   intr_req   interrupt request level to the CPU (registered)
//   intr_id    index of the presented source; valid while intr_req=1
//   intr_ack   CPU acknowledge pulse; only honoured while intr_req=1
//   cfg_we     config write strobe
//   cfg_addr   0 = mask, 1 = pending W1C, 2 = pending W1S / overrun count
//   cfg_wdata  config write data
//   cfg_rdata  combinational read data (mask / pending / overrun / zero)
//   fsm_state  debug view of the arbiter state (0 idle, 1 req, 2 gap)
//
// N_SRC must not exceed 2**ID_W.
// ---------------------------------------------------------------------------
module soft_intr_ctrl #(
  parameter int               N_SRC      = 4,
  parameter int               ID_W       = 2,
  parameter int               GAP_CYCLES = 4,
  parameter logic [N_SRC-1:0] MASK_RST   = {N_SRC{1'b1}}
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_SRC-1:0] src_pulse,
  output logic             intr_req,
  output logic [ID_W-1:0]  intr_id,
  input  logic             intr_ack,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [N_SRC-1:0] cfg_wdata,
  output logic [7:0]       cfg_rdata,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Counter wide enough for 0..GAP_CYCLES; at least one bit when GAP_CYCLES=0.
  localparam int GAP_W = $clog2(GAP_CYCLES + 2);

  // Only the low 8 sources fit in the read data bus.
  localparam int RD_N = (N_SRC < 8) ? N_SRC : 8;

  localparam logic [1:0] ADDR_MASK = 2'd0;
  localparam logic [1:0] ADDR_PEND = 2'd1;
  localparam logic [1:0] ADDR_SET  = 2'd2;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t             state;
  state_t             state_nxt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [GAP_W-1:0]   gap_cnt_nxt;
  logic [N_SRC-1:0]   pending;
  logic [N_SRC-1:0]   pending_nxt;
  logic [N_SRC-1:0]   mask;
  logic [N_SRC-1:0]   mask_nxt;
  logic [7:0]         overrun;
  logic [7:0]         overrun_nxt;

  // -------------------------------------------------------------------------
  // Datapath helpers
  // -------------------------------------------------------------------------
  logic [N_SRC-1:0]   sw_set;
  logic [N_SRC-1:0]   sw_clr;
  logic [N_SRC-1:0]   id_onehot;
  logic [N_SRC-1:0]   ack_clr;
  logic [N_SRC-1:0]   clr_all;
  logic [N_SRC-1:0]   eligible;
  logic [ID_W-1:0]    pick_id;
  logic               pick_valid;
  logic               ack_hit;
  logic               withdraw;
  logic               gap_done;
  logic               ovr_event;
  logic               ovr_clear;

  // Config write decode. All of these take effect on the next edge.
  always_comb begin
    sw_set    = '0;
    sw_clr    = '0;
    mask_nxt  = mask;
    ovr_clear = 1'b0;
    if (cfg_we) begin
      case (cfg_addr)
        ADDR_MASK: mask_nxt = cfg_wdata;
        ADDR_PEND: sw_clr   = cfg_wdata;
        ADDR_SET: begin
          sw_set    = cfg_wdata;
          // An all-zero write to the set register has no pending effect, so
          // it is reused as the overrun counter reset.
          ovr_clear = (cfg_wdata == '0);
        end
        default: ;
      endcase
    end
  end

  // One-hot of the presented id, used both for the ack clear and to look up
  // whether the presented source is still pending and enabled.
  always_comb begin
    id_onehot = '0;
    for (int i = 0; i < N_SRC; i++) begin
      id_onehot[i] = (intr_id == ID_W'(i));
    end
  end

  assign ack_hit = (state == ST_REQ) && intr_ack;
  assign ack_clr = ack_hit ? id_onehot : '0;
  assign clr_all = sw_clr | ack_clr;

  // A new event (hardware or software set) wins over any clear in the same
  // cycle, so an event arriving with its own ack is not lost.
  assign pending_nxt = (pending & ~clr_all) | src_pulse | sw_set;

  // An event that lands on a bit which is already pending and not being
  // cleared is an overrun. Several such bits in one cycle count once.
  assign ovr_event = |(src_pulse & pending & ~clr_all);

  always_comb begin
    overrun_nxt = overrun;
    if (ovr_clear) begin
      overrun_nxt = 8'd0;
    end else if (ovr_event && (overrun != 8'hFF)) begin
      overrun_nxt = overrun + 8'd1;
    end
  end

  // Fixed-priority pick: lowest enabled pending index.
  assign eligible   = pending & mask;
  assign pick_valid = |eligible;

  always_comb begin
    pick_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        pick_id = ID_W'(i);
      end
    end
  end

  // The presented source loses its pending or enable bit through a config
  // write. Looking at the next-edge values lets intr_req fall on the same
  // edge that the write lands on.
  assign withdraw = (state == ST_REQ) && !intr_ack &&
                    !(|(pending_nxt & mask_nxt & id_onehot));

  assign gap_done = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      gap_cnt  <= '0;
      intr_req <= 1'b0;
      intr_id  <= '0;
    end else begin
      state    <= state_nxt;
      gap_cnt  <= gap_cnt_nxt;
      // Registered request level: high exactly while the FSM sits in REQ.
      intr_req <= (state_nxt == ST_REQ);
      // The id is captured only on the idle-to-request transition and is
      // then frozen for the whole request.
      if ((state == ST_IDLE) && pick_valid) begin
        intr_id <= pick_id;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        // Ack is checked first so it beats a same-cycle withdraw.
        if (ack_hit) begin
          if (GAP_CYCLES > 0) begin
            state_nxt   = ST_GAP;
            gap_cnt_nxt = '0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (withdraw) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_done) begin
          state_nxt   = ST_IDLE;
          gap_cnt_nxt = '0;
        end else begin
          gap_cnt_nxt = gap_cnt + GAP_W'(1);
        end
      end
      default: begin
        state_nxt   = ST_IDLE;
        gap_cnt_nxt = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs (config read mux and debug state view)
  // -------------------------------------------------------------------------
  always_comb begin
    cfg_rdata = 8'd0;
    case (cfg_addr)
      ADDR_MASK: cfg_rdata[RD_N-1:0] = mask[RD_N-1:0];
      ADDR_PEND: cfg_rdata[RD_N-1:0] = pending[RD_N-1:0];
      ADDR_SET:  cfg_rdata           = overrun;
      default:   cfg_rdata           = 8'd0;
    endcase
    fsm_state = state;
  end

  // -------------------------------------------------------------------------
  // Pending, mask and overrun registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending <= '0;
      mask    <= MASK_RST;
      overrun <= 8'd0;
    end else begin
      pending <= pending_nxt;
      mask    <= mask_nxt;
      overrun <= overrun_nxt;
    end
  end

endmodule
